// File: rtl/cv32e40px_bitselect.sv
// Select engine: position of the k-th set bit of a 32-bit word.
// Iterative, CHUNK_W bits per cycle, valid/ready on both sides.
module cv32e40px_bitselect #(
  parameter int CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] in_i,
  input  logic [4:0]  rank_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [4:0]  pos_o,
  output logic        found_o
);

  localparam int NCH = 32 / CHUNK_W;
  localparam int CW  = $clog2(CHUNK_W) + 1;
  localparam int OW  = $clog2(CHUNK_W);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q;
  logic [31:0]        word_q;
  logic [4:0]         rem_q;
  logic [IW-1:0]      c_q;
  logic [4:0]         pos_q;
  logic               found_q;

  logic [4:0]         base;
  logic [CHUNK_W-1:0] chunk;
  logic [CW-1:0]      cnt;
  logic [5:0]         run;
  logic [OW-1:0]      off;
  logic               hit;

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign pos_o   = pos_q;
  assign found_o = found_q;

  // Current chunk, its popcount and the offset of the rem_q-th one
  always_comb begin
    base  = 5'(int'(c_q) * CHUNK_W);
    chunk = word_q[base +: CHUNK_W];
    cnt   = '0;
    run   = '0;
    off   = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      cnt = cnt + CW'(chunk[i]);
      if (chunk[i]) begin
        if (run == {1'b0, rem_q}) off = OW'(i);
        run = run + 6'd1;
      end
    end
    hit = ({1'b0, rem_q} < 6'(cnt));
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      rem_q   <= '0;
      c_q     <= '0;
      pos_q   <= '0;
      found_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            word_q  <= in_i;
            rem_q   <= rank_i;
            c_q     <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            pos_q   <= base + 5'(off);
            found_q <= 1'b1;
            state_q <= DONE;
          end else if (c_q == LAST) begin
            pos_q   <= '0;
            found_q <= 1'b0;
            state_q <= DONE;
          end else begin
            rem_q <= rem_q - 5'(cnt);
            c_q   <= c_q + IW'(1);
          end
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
